// File: rtl/motion_update_broadcast_arbiter.sv
// Round-robin merge of motion-update requesters onto the shared position broadcast bus,
// sequencing one pass: enable high while broadcasting, then a swap wait, then a done pulse.
module motion_update_broadcast_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CELL_ID_WIDTH = 4,
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned SWAP_WAIT     = 3,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*3*DATA_WIDTH-1:0]      req_data,
    input  logic [NUM_REQ*3*CELL_ID_WIDTH-1:0]   req_dst_cell,
    input  logic [NUM_REQ-1:0]                   req_done,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]              out_data,
    output logic [3*CELL_ID_WIDTH-1:0]           out_data_dst_cell,
    output logic                                 out_data_valid,
    output logic                                 busy,
    output logic                                 done,
    output logic [CNT_WIDTH-1:0]                 beat_count
);

    localparam int unsigned DW = 3 * DATA_WIDTH;
    localparam int unsigned CW = 3 * CELL_ID_WIDTH;
    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SW = (SWAP_WAIT > 1) ? $clog2(SWAP_WAIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BROADCAST,
        S_SWAP,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [PW-1:0]        r_rr_ptr;
    logic [NUM_REQ-1:0]   r_done_flags;
    logic [SW-1:0]        r_swap_cnt;
    logic [DW-1:0]        r_out_data;
    logic [CW-1:0]        r_out_dst;
    logic                 r_out_valid;
    logic [CNT_WIDTH-1:0] r_beat_count;

    logic [PW-1:0]        w_idx;
    logic [PW-1:0]        w_sel;
    logic                 w_found;
    logic [NUM_REQ-1:0]   w_grant;
    logic [DW-1:0]        w_grant_data;
    logic [CW-1:0]        w_grant_dst;
    logic                 w_xfer;
    logic                 w_exit;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_idx        = '0;
        w_sel        = '0;
        w_found      = 1'b0;
        w_grant      = '0;
        w_grant_data = '0;
        w_grant_dst  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = PW'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_found && (w_sel == PW'(i))) begin
                w_grant[i]   = 1'b1;
                w_grant_data = req_data[i*DW +: DW];
                w_grant_dst  = req_dst_cell[i*CW +: CW];
            end
        end
    end

    assign w_xfer = (r_state == S_BROADCAST) && w_found;
    assign w_exit = (&(r_done_flags | req_done)) && !(|req_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        req_ready            = '0;
        motion_update_enable = 1'b0;
        busy                 = 1'b1;
        done                 = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = S_BROADCAST;
                end
            end
            S_BROADCAST: begin
                motion_update_enable = 1'b1;
                req_ready            = w_grant;
                if (w_exit) begin
                    w_state_next = S_SWAP;
                end
            end
            S_SWAP: begin
                if (r_swap_cnt == SW'(SWAP_WAIT - 1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Exit requires no req_valid, so a transfer never coincides with leaving BROADCAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= PW'(NUM_REQ - 1);
            r_done_flags <= '0;
            r_swap_cnt   <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_dst    <= '0;
            r_beat_count <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_dst   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_done_flags <= '0;
                        r_beat_count <= '0;
                    end
                end
                S_BROADCAST: begin
                    r_done_flags <= r_done_flags | req_done;
                    r_swap_cnt   <= '0;
                    if (w_xfer) begin
                        r_rr_ptr    <= w_sel;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_grant_data;
                        r_out_dst   <= w_grant_dst;
                        if (r_beat_count != '1) begin
                            r_beat_count <= r_beat_count + 1'b1;
                        end
                    end
                end
                S_SWAP: begin
                    r_swap_cnt <= r_swap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_data          = r_out_data;
    assign out_data_dst_cell = r_out_dst;
    assign out_data_valid    = r_out_valid;
    assign beat_count        = r_beat_count;

endmodule

// File: tb/tb_motion_update_broadcast_arbiter.sv
// Directed bench: requesters react to grants, broadcast beats are checked against a queue.
module tb_motion_update_broadcast_arbiter;

    localparam int DW  = 32;
    localparam int CW  = 4;
    localparam int NR  = 4;
    localparam int SWW = 3;
    localparam int CNW = 16;

    typedef logic [3*CW+3*DW-1:0] beat_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [NR-1:0]         req_valid;
    logic [NR*3*DW-1:0]    req_data;
    logic [NR*3*CW-1:0]    req_dst_cell;
    logic [NR-1:0]         req_done;
    logic [NR-1:0]         req_ready;
    logic                  motion_update_enable;
    logic [3*DW-1:0]       out_data;
    logic [3*CW-1:0]       out_data_dst_cell;
    logic                  out_data_valid;
    logic                  busy;
    logic                  done;
    logic [CNW-1:0]        beat_count;

    motion_update_broadcast_arbiter #(
        .DATA_WIDTH   (DW),
        .CELL_ID_WIDTH(CW),
        .NUM_REQ      (NR),
        .SWAP_WAIT    (SWW),
        .CNT_WIDTH    (CNW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .req_valid           (req_valid),
        .req_data            (req_data),
        .req_dst_cell        (req_dst_cell),
        .req_done            (req_done),
        .req_ready           (req_ready),
        .motion_update_enable(motion_update_enable),
        .out_data            (out_data),
        .out_data_dst_cell   (out_data_dst_cell),
        .out_data_valid      (out_data_valid),
        .busy                (busy),
        .done                (done),
        .beat_count          (beat_count)
    );

    int    total = 0;
    int    bad = 0;
    int    en_cycles = 0;
    beat_t sb_q[$];
    beat_t sb_exp;
    int    remaining[NR];
    int    sent[NR];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3*DW-1:0] data_of(input int i, input int k);
        return {32'(k + 1), 32'(i), 32'hC0DE0000 + 32'(i * 16 + k)};
    endfunction

    function automatic logic [3*CW-1:0] dst_of(input int i, input int k);
        return 12'((i + 1) * 256 + k * 16 + i);
    endfunction

    function automatic beat_t beat_of(input int i, input int k);
        return {dst_of(i, k), data_of(i, k)};
    endfunction

    // Bus monitor: every valid beat must match the oldest expected beat and appear under enable.
    always @(negedge clk) begin
        if (motion_update_enable) en_cycles++;
        if (out_data_valid) begin
            check("beat_under_enable", 128'(motion_update_enable), 128'(1));
            if (sb_q.size() == 0) begin
                check("unexpected_beat", 128'(out_data_valid), 128'(0));
            end else begin
                sb_exp = sb_q.pop_front();
                check("beat_payload", 128'({out_data_dst_cell, out_data}), 128'(sb_exp));
            end
        end else begin
            check("idle_bus_zero", 128'({out_data_dst_cell, out_data}), 128'(0));
        end
    end

    task automatic start_pass();
        start     = 1'b1;
        en_cycles = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Requesters hold valid until granted, then advance; done is a level once drained.
    task automatic run_requesters(input logic [NR-1:0] done_with_last);
        logic [NR-1:0] g;
        int guard = 0;
        while ((remaining[0] + remaining[1] + remaining[2] + remaining[3]) > 0 && guard < 60) begin
            for (int i = 0; i < NR; i++) begin
                req_valid[i] = (remaining[i] > 0);
                req_done[i]  = (remaining[i] == 0) || (done_with_last[i] && remaining[i] == 1);
                req_data[i*3*DW +: 3*DW]     = data_of(i, sent[i]);
                req_dst_cell[i*3*CW +: 3*CW] = dst_of(i, sent[i]);
            end
            #1;
            check("grant_onehot", 128'($onehot(req_ready)), 128'(1));
            g = req_ready & req_valid;
            @(posedge clk);
            for (int i = 0; i < NR; i++) begin
                if (g[i]) begin
                    sent[i]++;
                    remaining[i]--;
                end
            end
            @(negedge clk);
            guard++;
        end
        check("drain_budget", 128'(guard < 60), 128'(1));
        req_valid = '0;
        req_done  = '1;
    endtask

    task automatic finish_pass(input int exp_beats, input int exp_en, input bit poke_start);
        int n = 0;
        int k = 0;
        while (motion_update_enable === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("enable_fell", 128'(motion_update_enable), 128'(0));
        start = poke_start;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            start = 1'b0;
            k++;
        end
        start = 1'b0;
        check("done_latency", 128'(k), 128'(SWW));
        check("busy_at_done", 128'(busy), 128'(1));
        check("beat_count", 128'(beat_count), 128'(exp_beats));
        if (exp_en >= 0) check("enable_cycles", 128'(en_cycles), 128'(exp_en));
        @(negedge clk);
        check("done_one_cycle", 128'(done), 128'(0));
        check("idle_after_done", 128'(busy), 128'(0));
        check("scoreboard_drained", 128'(sb_q.size()), 128'(0));
        check("beat_count_hold", 128'(beat_count), 128'(exp_beats));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        req_valid    = '1;
        req_done     = '0;
        req_data     = '0;
        req_dst_cell = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_enable", 128'(motion_update_enable), 128'(0));
        check("rst_ready", 128'(req_ready), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_beats", 128'(beat_count), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_ignores_valid", 128'(req_ready), 128'(0));
        check("idle_enable", 128'(motion_update_enable), 128'(0));
        req_valid = '0;
        @(negedge clk);

        // 1: four single beats at once, granted 0,1,2,3
        for (int i = 0; i < NR; i++) begin
            remaining[i] = 1;
            sent[i]      = 0;
            sb_q.push_back(beat_of(i, 0));
        end
        start_pass();
        run_requesters('0);
        finish_pass(4, 5, 1'b0);

        // 2: requesters 0 and 2 stream three beats each, grants must alternate
        for (int i = 0; i < NR; i++) begin
            remaining[i] = (i == 0 || i == 2) ? 3 : 0;
            sent[i]      = 0;
        end
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back(beat_of(0, k));
            sb_q.push_back(beat_of(2, k));
        end
        start_pass();
        run_requesters('0);
        finish_pass(6, 7, 1'b0);

        // 3: empty pass, everyone already done
        for (int i = 0; i < NR; i++) begin
            remaining[i] = 0;
            sent[i]      = 0;
        end
        start_pass();
        run_requesters('0);
        finish_pass(0, 1, 1'b0);

        // 4: valid and done in the same cycle
        req_done = '0;
        start_pass();
        req_valid = 4'b0010;
        req_done  = 4'b1111;
        req_data[1*3*DW +: 3*DW]     = 96'h1;
        req_dst_cell[1*3*CW +: 3*CW] = 12'h423;
        sb_q.push_back({12'h423, 96'h1});
        #1;
        check("vd_grant", 128'(req_ready), 128'(4'b0010));
        @(negedge clk);
        req_valid = '0;
        check("vd_enable_with_beat", 128'(motion_update_enable), 128'(1));
        finish_pass(1, 2, 1'b0);

        // 5a: start ignored in BROADCAST and SWAP; done flags are sticky
        req_done = '0;
        start_pass();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_enable", 128'(motion_update_enable), 128'(1));
        check("restart_beats", 128'(beat_count), 128'(0));
        req_done = 4'b0101;
        @(negedge clk);
        check("partial_done_holds", 128'(motion_update_enable), 128'(1));
        req_done = 4'b1010;
        @(negedge clk);
        req_done = '0;
        finish_pass(0, -1, 1'b1);

        // 5b: reset in the middle of a pass
        start_pass();
        req_valid = 4'b0001;
        req_data[0 +: 3*DW]     = data_of(0, 7);
        req_dst_cell[0 +: 3*CW] = dst_of(0, 7);
        sb_q.push_back(beat_of(0, 7));
        @(negedge clk);
        check("pre_rst_beats", 128'(beat_count), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_enable", 128'(motion_update_enable), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_valid", 128'(out_data_valid), 128'(0));
        check("midrst_ready", 128'(req_ready), 128'(0));
        check("midrst_beats", 128'(beat_count), 128'(0));
        rst       = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("midrst_no_done", 128'(done), 128'(0));
        end
        check("midrst_sb_drained", 128'(sb_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
